// File: rtl/sum_result_fifo_if.sv
// Adder-result capture bus: producer side (adder + consumer) is master,
// the FIFO is slave. Signal names keep the adder block's naming.
interface sum_result_fifo_if #(
  parameter int DEPTH = 4,
  parameter int ACC_W = 16
);
  localparam int CNT_W = $clog2(DEPTH + 1);

  // Handshake: a read transfer happens on a rising edge where Rd_valid and
  // Rd_ready are both high; Rd_data must be stable while Rd_valid is high and
  // Rd_ready is low. Data_ready has no back-pressure: each high cycle is one word.
  logic [7:0]       Sum_result;
  logic             Sum_carry;
  logic             Data_ready;
  logic             Rd_ready;
  logic             Rd_valid;
  logic [8:0]       Rd_data;
  logic [CNT_W-1:0] Fifo_count;
  logic             Fifo_full;
  logic             Fifo_empty;
  logic             Overflow;
  logic             Clr_overflow;
  logic [ACC_W-1:0] Acc_total;
  logic             Acc_clear;

  modport master (
    output Sum_result, Sum_carry, Data_ready, Rd_ready, Clr_overflow, Acc_clear,
    input  Rd_valid, Rd_data, Fifo_count, Fifo_full, Fifo_empty, Overflow, Acc_total
  );

  modport slave (
    input  Sum_result, Sum_carry, Data_ready, Rd_ready, Clr_overflow, Acc_clear,
    output Rd_valid, Rd_data, Fifo_count, Fifo_full, Fifo_empty, Overflow, Acc_total
  );
endinterface

// File: rtl/sum_result_fifo.sv
// Buffers adder result words in a first-word-fall-through FIFO, with a running
// accumulator of accepted words and a sticky overflow flag for dropped words.
module sum_result_fifo #(
  parameter int DEPTH = 4,
  parameter int ACC_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  sum_result_fifo_if.slave  bus
);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [8:0]       mem [DEPTH];
  logic [PW-1:0]    wr_ptr, rd_ptr, rd_ptr_nxt;
  logic [CNT_W-1:0] count, count_nxt;
  logic             valid_q, full_q, empty_q, overflow_q;
  logic [8:0]       head_q, head_nxt;
  logic [ACC_W-1:0] acc_q;
  logic [8:0]       word;
  logic             pop, push, drop;

  always_comb begin
    word = {bus.Sum_carry, bus.Sum_result};
    pop  = valid_q & bus.Rd_ready;
    push = bus.Data_ready & (~full_q | pop);
    drop = bus.Data_ready & full_q & ~pop;

    count_nxt = count;
    case ({push, pop})
      2'b10:   count_nxt = count + CNT_W'(1);
      2'b01:   count_nxt = count - CNT_W'(1);
      default: count_nxt = count;
    endcase

    rd_ptr_nxt = pop ? rd_ptr + PW'(1) : rd_ptr;

    // The new head is the word being written only when it lands exactly at
    // the next read slot (empty FIFO, or one entry being replaced in-cycle).
    head_nxt = head_q;
    if (count_nxt != '0) begin
      if (push && (rd_ptr_nxt == wr_ptr)) head_nxt = word;
      else                                 head_nxt = mem[rd_ptr_nxt];
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= word;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      valid_q    <= 1'b0;
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
      overflow_q <= 1'b0;
      head_q     <= '0;
      acc_q      <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      rd_ptr  <= rd_ptr_nxt;
      count   <= count_nxt;
      valid_q <= (count_nxt != '0);
      empty_q <= (count_nxt == '0);
      full_q  <= (count_nxt == CNT_W'(DEPTH));
      head_q  <= head_nxt;

      // A drop in the same cycle as a clear keeps the flag set.
      if (drop)                  overflow_q <= 1'b1;
      else if (bus.Clr_overflow) overflow_q <= 1'b0;

      if (bus.Acc_clear) acc_q <= push ? ACC_W'(word) : '0;
      else if (push)     acc_q <= acc_q + ACC_W'(word);
    end
  end

  assign bus.Rd_valid   = valid_q;
  assign bus.Rd_data    = head_q;
  assign bus.Fifo_count = count;
  assign bus.Fifo_full  = full_q;
  assign bus.Fifo_empty = empty_q;
  assign bus.Overflow   = overflow_q;
  assign bus.Acc_total  = acc_q;

endmodule

// File: tb/tb_sum_result_fifo.sv
// Directed bench for sum_result_fifo: one default instance plus a 9-bit
// accumulator instance to exercise accumulator wrap.
module tb_sum_result_fifo;
  logic clk;
  logic reset;
  int   n_cmp;
  int   n_fail;

  sum_result_fifo_if #(.DEPTH(4), .ACC_W(16)) bus0 ();
  sum_result_fifo_if #(.DEPTH(4), .ACC_W(9))  bus1 ();

  sum_result_fifo #(.DEPTH(4), .ACC_W(16)) u0 (.clk(clk), .reset(reset), .bus(bus0.slave));
  sum_result_fifo #(.DEPTH(4), .ACC_W(9))  u1 (.clk(clk), .reset(reset), .bus(bus1.slave));

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic drive0(input logic dr, input logic [8:0] w, input logic rr);
    bus0.Data_ready = dr;
    bus0.Sum_carry  = w[8];
    bus0.Sum_result = w[7:0];
    bus0.Rd_ready   = rr;
  endtask

  task automatic idle0();
    drive0(1'b0, 9'h000, 1'b0);
    bus0.Clr_overflow = 1'b0;
    bus0.Acc_clear    = 1'b0;
  endtask

  task automatic push0(input logic [8:0] w);
    drive0(1'b1, w, 1'b0);
    tick();
    idle0();
  endtask

  task automatic pop0();
    drive0(1'b0, 9'h000, 1'b1);
    tick();
    idle0();
  endtask

  initial begin
    n_cmp  = 0;
    n_fail = 0;
    reset  = 1'b1;
    idle0();
    bus1.Data_ready = 1'b0; bus1.Sum_carry = 1'b0; bus1.Sum_result = 8'h00;
    bus1.Rd_ready = 1'b0; bus1.Clr_overflow = 1'b0; bus1.Acc_clear = 1'b0;
    tick(); tick();

    check("rst_count", 32'(bus0.Fifo_count), 0);
    check("rst_empty", 32'(bus0.Fifo_empty), 1);
    check("rst_full",  32'(bus0.Fifo_full), 0);
    check("rst_valid", 32'(bus0.Rd_valid), 0);
    check("rst_ovf",   32'(bus0.Overflow), 0);
    check("rst_acc",   32'(bus0.Acc_total), 0);
    check("rst_data",  32'(bus0.Rd_data), 0);
    reset = 1'b0;
    tick();

    // single word, one-cycle latency
    push0(9'h1FF);
    check("t1_valid", 32'(bus0.Rd_valid), 1);
    check("t1_data",  32'(bus0.Rd_data), 32'h1FF);
    check("t1_count", 32'(bus0.Fifo_count), 1);
    check("t1_acc",   32'(bus0.Acc_total), 32'h1FF);
    pop0();
    check("t1_empty", 32'(bus0.Fifo_empty), 1);
    bus0.Acc_clear = 1'b1; tick(); idle0();
    check("t1_accclr", 32'(bus0.Acc_total), 0);

    // fill, overflow drop, drain
    push0(9'h001); push0(9'h002); push0(9'h003); push0(9'h004);
    check("t2_full4",  32'(bus0.Fifo_full), 1);
    check("t2_ovf0",   32'(bus0.Overflow), 0);
    push0(9'h005);
    check("t2_ovf1",   32'(bus0.Overflow), 1);
    check("t2_count",  32'(bus0.Fifo_count), 4);
    check("t2_acc",    32'(bus0.Acc_total), 32'h00A);
    for (int i = 1; i <= 4; i++) begin
      check($sformatf("t2_pop%0d", i), 32'(bus0.Rd_data), 32'(i));
      pop0();
    end
    check("t2_empty", 32'(bus0.Fifo_empty), 1);
    check("t2_valid", 32'(bus0.Rd_valid), 0);
    bus0.Clr_overflow = 1'b1; tick(); idle0();
    check("t2_clrovf", 32'(bus0.Overflow), 0);

    // push and pop together while full
    push0(9'h010); push0(9'h011); push0(9'h012); push0(9'h013);
    drive0(1'b1, 9'h0AA, 1'b1); tick(); idle0();
    check("t3_count", 32'(bus0.Fifo_count), 4);
    check("t3_full",  32'(bus0.Fifo_full), 1);
    check("t3_ovf",   32'(bus0.Overflow), 0);
    check("t3_acc",   32'(bus0.Acc_total), 32'h0FA);
    check("t3_d0", 32'(bus0.Rd_data), 32'h011); pop0();
    check("t3_d1", 32'(bus0.Rd_data), 32'h012); pop0();
    check("t3_d2", 32'(bus0.Rd_data), 32'h013); pop0();
    check("t3_d3", 32'(bus0.Rd_data), 32'h0AA); pop0();
    check("t3_empty", 32'(bus0.Fifo_empty), 1);

    // streaming through a single slot, pointers wrap several times
    for (int i = 0; i < 10; i++) begin
      drive0(1'b1, 9'(32'h20 + i), 1'b1);
      tick();
      check($sformatf("t4_data%0d", i), 32'(bus0.Rd_data), 32'h20 + i);
      check($sformatf("t4_cnt%0d", i),  32'(bus0.Fifo_count), 1);
    end
    drive0(1'b0, 9'h000, 1'b1); tick(); idle0();
    check("t4_empty", 32'(bus0.Fifo_empty), 1);
    check("t4_ovf",   32'(bus0.Overflow), 0);

    // drop beats clear, then async reset mid-operation
    push0(9'h031); push0(9'h032); push0(9'h033); push0(9'h034);
    drive0(1'b1, 9'h035, 1'b0); bus0.Clr_overflow = 1'b1; tick(); idle0();
    check("t6_setwins", 32'(bus0.Overflow), 1);
    pop0();
    check("t6_count3", 32'(bus0.Fifo_count), 3);
    check("t6_head",   32'(bus0.Rd_data), 32'h032);
    reset = 1'b1;
    #1;
    check("t6_rcount", 32'(bus0.Fifo_count), 0);
    check("t6_rvalid", 32'(bus0.Rd_valid), 0);
    check("t6_rovf",   32'(bus0.Overflow), 0);
    check("t6_racc",   32'(bus0.Acc_total), 0);
    check("t6_rempty", 32'(bus0.Fifo_empty), 1);
    tick();
    reset = 1'b0;
    tick();
    push0(9'h077);
    check("t6_after", 32'(bus0.Rd_data), 32'h077);
    check("t6_acnt",  32'(bus0.Fifo_count), 1);

    // 9-bit accumulator wrap and clear-with-push
    bus1.Data_ready = 1'b1; bus1.Sum_carry = 1'b1; bus1.Sum_result = 8'hFF;
    tick(); tick();
    check("t5_wrap", 32'(bus1.Acc_total), 32'h1FE);
    bus1.Sum_carry = 1'b0; bus1.Sum_result = 8'h05; bus1.Acc_clear = 1'b1;
    tick();
    bus1.Data_ready = 1'b0; bus1.Acc_clear = 1'b0;
    check("t5_clrpush", 32'(bus1.Acc_total), 32'h005);
    check("t5_count",   32'(bus1.Fifo_count), 3);
    check("t5_head",    32'(bus1.Rd_data), 32'h1FF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
